// File: rtl/doubly_linked_list.sv
// Doubly linked list over register node storage, driven by a busy/done op handshake.
// Build option DLL_DELETE_ALL_EN: Delete_value removes every matching node instead of the first.
module doubly_linked_list #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_NODE   = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [2:0]            op,
    input  logic                  op_start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  op_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] next_node_addr,
    output logic [ADDR_WIDTH-1:0] pre_node_addr,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic [ADDR_WIDTH-1:0] length,
    output logic                  full,
    output logic                  empty,
    output logic                  fault
);
    localparam int unsigned IDX_WIDTH = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] NULL_A = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] MAX_A  = ADDR_WIDTH'(MAX_NODE);

    typedef enum logic [2:0] {
        OP_READ, OP_DEL_VAL, OP_PUSH_B, OP_PUSH_F, OP_POP_B, OP_POP_F, OP_INS_B, OP_DEL_AT
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_FIND, S_EXEC, S_DONE} state_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
`ifdef DLL_DELETE_ALL_EN
    logic                  hit_q, hit_d;
`endif
    logic [DATA_WIDTH-1:0] mem_q [MAX_NODE];
    logic [DATA_WIDTH-1:0] mem_d [MAX_NODE];
    logic [ADDR_WIDTH-1:0] nxt_q [MAX_NODE];
    logic [ADDR_WIDTH-1:0] nxt_d [MAX_NODE];
    logic [ADDR_WIDTH-1:0] prv_q [MAX_NODE];
    logic [ADDR_WIDTH-1:0] prv_d [MAX_NODE];
    logic [MAX_NODE-1:0]   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d, len_q, len_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] nout_q, nout_d, pout_q, pout_d;
    logic                  done_q, done_d, busy_q, busy_d, fault_q, fault_d;

    logic [ADDR_WIDTH-1:0] free_a, rm_a, rm_p, rm_n, ins_p, ins_n;
    logic                  do_add, do_rm, tgt_ok, full_c;

    function automatic logic [IDX_WIDTH-1:0] ix(input logic [ADDR_WIDTH-1:0] a);
        return IDX_WIDTH'(a);
    endfunction

    assign full_c = (len_q == MAX_A);
    assign tgt_ok = (tgt_q < MAX_A) && valid_q[ix(tgt_q)];

    // Lowest-index free slot; NULL when every slot is in use.
    always_comb begin
        free_a = NULL_A;
        for (int i = int'(MAX_NODE) - 1; i >= 0; i--) begin
            if (!valid_q[IDX_WIDTH'(i)]) free_a = ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dat_d   = dat_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
`ifdef DLL_DELETE_ALL_EN
        hit_d   = hit_q;
`endif
        mem_d   = mem_q;
        nxt_d   = nxt_q;
        prv_d   = prv_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        len_d   = len_q;
        dout_d  = dout_q;
        nout_d  = nout_q;
        pout_d  = pout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        fault_d = fault_q;
        do_add  = 1'b0;
        do_rm   = 1'b0;
        rm_a    = NULL_A;
        rm_p    = NULL_A;
        rm_n    = NULL_A;
        ins_p   = NULL_A;
        ins_n   = NULL_A;

        case (state_q)
            S_IDLE: begin
                // busy_q still set here means this is the op_done cycle.
                if (busy_q) begin
                    busy_d  = 1'b0;
                    fault_d = 1'b0;
                end else if (op_start) begin
                    op_d    = op_e'(op);
                    dat_d   = data_in;
                    tgt_d   = addr_in;
                    busy_d  = 1'b1;
                    state_d = S_EXEC;
                    if (op_e'(op) == OP_DEL_VAL) begin
`ifdef DLL_DELETE_ALL_EN
                        hit_d   = 1'b0;
                        cur_d   = head_q;
                        state_d = (head_q == NULL_A) ? S_EXEC : S_FIND;
`else
                        // Head is compared at acceptance so a head match costs no search cycle.
                        if (head_q == NULL_A) begin
                            fault_d = 1'b1;
                            state_d = S_DONE;
                        end else if (mem_q[ix(head_q)] == data_in) begin
                            tgt_d = head_q;
                        end else begin
                            cur_d   = nxt_q[ix(head_q)];
                            state_d = S_FIND;
                        end
`endif
                    end
                end
            end
            S_FIND: begin
`ifdef DLL_DELETE_ALL_EN
                if (mem_q[ix(cur_q)] == dat_q) begin
                    do_rm = 1'b1;
                    rm_a  = cur_q;
                    hit_d = 1'b1;
                end
                cur_d = nxt_q[ix(cur_q)];
                if (nxt_q[ix(cur_q)] == NULL_A) state_d = S_EXEC;
`else
                if (cur_q == NULL_A) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (mem_q[ix(cur_q)] == dat_q) begin
                    tgt_d   = cur_q;
                    state_d = S_EXEC;
                end else begin
                    cur_d = nxt_q[ix(cur_q)];
                end
`endif
            end
            S_EXEC: begin
                state_d = S_DONE;
                fault_d = 1'b0;
                case (op_q)
                    OP_READ: begin
                        if (!tgt_ok) fault_d = 1'b1;
                        else begin
                            dout_d = mem_q[ix(tgt_q)];
                            nout_d = nxt_q[ix(tgt_q)];
                            pout_d = prv_q[ix(tgt_q)];
                        end
                    end
                    OP_DEL_VAL: begin
`ifdef DLL_DELETE_ALL_EN
                        fault_d = !hit_q;
                        dout_d  = dat_q;
`else
                        do_rm = 1'b1;
                        rm_a  = tgt_q;
`endif
                    end
                    OP_PUSH_B: begin
                        if (full_c) fault_d = 1'b1;
                        else begin
                            do_add = 1'b1;
                            ins_p  = tail_q;
                        end
                    end
                    OP_PUSH_F: begin
                        if (full_c) fault_d = 1'b1;
                        else begin
                            do_add = 1'b1;
                            ins_n  = head_q;
                        end
                    end
                    OP_POP_B, OP_POP_F: begin
                        if (len_q == '0) fault_d = 1'b1;
                        else begin
                            do_rm = 1'b1;
                            rm_a  = (op_q == OP_POP_B) ? tail_q : head_q;
                        end
                    end
                    OP_INS_B: begin
                        if (full_c || !tgt_ok) fault_d = 1'b1;
                        else begin
                            do_add = 1'b1;
                            ins_p  = prv_q[ix(tgt_q)];
                            ins_n  = tgt_q;
                        end
                    end
                    OP_DEL_AT: begin
                        if (!tgt_ok) fault_d = 1'b1;
                        else begin
                            do_rm = 1'b1;
                            rm_a  = tgt_q;
                        end
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Unlink rm_a: splice its neighbours together and free the slot.
        if (do_rm) begin
            rm_p = prv_q[ix(rm_a)];
            rm_n = nxt_q[ix(rm_a)];
            if (rm_p != NULL_A) nxt_d[ix(rm_p)] = rm_n;
            else                head_d = rm_n;
            if (rm_n != NULL_A) prv_d[ix(rm_n)] = rm_p;
            else                tail_d = rm_p;
            valid_d[ix(rm_a)] = 1'b0;
            nxt_d[ix(rm_a)]   = NULL_A;
            prv_d[ix(rm_a)]   = NULL_A;
            len_d  = len_q - ADDR_WIDTH'(1);
            dout_d = mem_q[ix(rm_a)];
            nout_d = rm_n;
            pout_d = rm_p;
        end

        // Link the free slot between ins_p and ins_n (NULL ends mean head/tail).
        if (do_add) begin
            mem_d[ix(free_a)]   = dat_q;
            valid_d[ix(free_a)] = 1'b1;
            nxt_d[ix(free_a)]   = ins_n;
            prv_d[ix(free_a)]   = ins_p;
            if (ins_p != NULL_A) nxt_d[ix(ins_p)] = free_a;
            else                 head_d = free_a;
            if (ins_n != NULL_A) prv_d[ix(ins_n)] = free_a;
            else                 tail_d = free_a;
            len_d  = len_q + ADDR_WIDTH'(1);
            nout_d = ins_n;
            pout_d = ins_p;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            dat_q   <= '0;
            tgt_q   <= NULL_A;
            cur_q   <= NULL_A;
`ifdef DLL_DELETE_ALL_EN
            hit_q   <= 1'b0;
`endif
            mem_q   <= '{default: '0};
            nxt_q   <= '{default: NULL_A};
            prv_q   <= '{default: NULL_A};
            valid_q <= '0;
            head_q  <= NULL_A;
            tail_q  <= NULL_A;
            len_q   <= '0;
            dout_q  <= '0;
            nout_q  <= NULL_A;
            pout_q  <= NULL_A;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dat_q   <= dat_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
`ifdef DLL_DELETE_ALL_EN
            hit_q   <= hit_d;
`endif
            mem_q   <= mem_d;
            nxt_q   <= nxt_d;
            prv_q   <= prv_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            nout_q  <= nout_d;
            pout_q  <= pout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign data_out       = dout_q;
    assign op_done        = done_q;
    assign busy           = busy_q;
    assign next_node_addr = nout_q;
    assign pre_node_addr  = pout_q;
    assign head           = head_q;
    assign tail           = tail_q;
    assign length         = len_q;
    assign fault          = fault_q;
    assign full           = full_c;
    assign empty          = (len_q == '0);

endmodule

// File: tb/tb_doubly_linked_list.sv
// Directed scoreboard bench for doubly_linked_list (8 slots, 8-bit payload).
module tb_doubly_linked_list;
    localparam logic [3:0] NUL = 4'hF;
    localparam logic [2:0] RD = 3'd0, DV = 3'd1, PB = 3'd2, PF = 3'd3,
                           OB = 3'd4, OF = 3'd5, IB = 3'd6, DA = 3'd7;
`ifdef DLL_DELETE_ALL_EN
    localparam int LAT_DV34 = 5, LAT_DV99 = 4;
`else
    localparam int LAT_DV34 = 4, LAT_DV99 = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_in = '0;
    logic [2:0] op = '0;
    logic       op_start = 1'b0;
    logic [7:0] data_out;
    logic       op_done, busy, full, empty, fault;
    logic [3:0] next_node_addr, pre_node_addr, head, tail, length;

    always #5 clk = ~clk;

    doubly_linked_list dut (
        .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in), .op(op),
        .op_start(op_start), .data_out(data_out), .op_done(op_done), .busy(busy),
        .next_node_addr(next_node_addr), .pre_node_addr(pre_node_addr),
        .head(head), .tail(tail), .length(length), .full(full), .empty(empty),
        .fault(fault)
    );

    typedef struct {
        logic [7:0] data;
        bit         chk_data;
        logic       fault;
        logic [3:0] head, tail, len, nxt, pre;
        bit         chk_links;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [7:0] d, bit cd, logic f, logic [3:0] h, logic [3:0] t,
                                logic [3:0] l, logic [3:0] nx, logic [3:0] pr, bit cl, int lat);
        exp_t e;
        e.data = d; e.chk_data = cd; e.fault = f; e.head = h; e.tail = t; e.len = l;
        e.nxt = nx; e.pre = pr; e.chk_links = cl; e.lat = lat;
        return e;
    endfunction

    // Issue one op; with disturb set, inputs are changed and op_start re-pulsed while busy.
    task automatic run(input string tag, input logic [2:0] o, input logic [7:0] d,
                       input logic [3:0] a, input exp_t e, input bit disturb = 1'b0);
        exp_t g;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        op = o; data_in = d; addr_in = a; op_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        chk({tag, ":busy"}, busy, 1);
        if (disturb) begin
            data_in = 8'd12; op = PB; op_start = 1'b1;
        end
        while (!op_done && n < 40) begin
            @(negedge clk);
            op_start = 1'b0;
            n++;
        end
        g = sb.pop_front();
        chk({tag, ":latency"}, n, g.lat);
        chk({tag, ":fault"}, fault, g.fault);
        chk({tag, ":head"}, head, g.head);
        chk({tag, ":tail"}, tail, g.tail);
        chk({tag, ":length"}, length, g.len);
        chk({tag, ":full"}, full, (g.len == 4'd8));
        chk({tag, ":empty"}, empty, (g.len == 4'd0));
        if (g.chk_data) chk({tag, ":data"}, data_out, g.data);
        if (g.chk_links) begin
            chk({tag, ":next"}, next_node_addr, g.nxt);
            chk({tag, ":pre"}, pre_node_addr, g.pre);
        end
        @(negedge clk);
        chk({tag, ":done_low"}, op_done, 0);
        chk({tag, ":idle"}, busy, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":data_out"}, data_out, 0);
        chk({tag, ":op_done"}, op_done, 0);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":fault"}, fault, 0);
        chk({tag, ":head"}, head, NUL);
        chk({tag, ":tail"}, tail, NUL);
        chk({tag, ":next"}, next_node_addr, NUL);
        chk({tag, ":pre"}, pre_node_addr, NUL);
        chk({tag, ":length"}, length, 0);
        chk({tag, ":empty"}, empty, 1);
        chk({tag, ":full"}, full, 0);
    endtask

    initial begin
        logic [3:0] slots [6];
        logic [7:0] pdat [8];
        logic [3:0] phead [8];
        slots = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};
        pdat  = '{8'd7, 8'd12, 8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105};
        phead = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, NUL};

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        run("pb12", PB, 8'd12, 4'd0, mk(0, 0, 0, 4'd0, 4'd0, 4'd1, NUL, NUL, 1, 2));
        run("pb34", PB, 8'd34, 4'd0, mk(0, 0, 0, 4'd0, 4'd1, 4'd2, NUL, 4'd0, 1, 2));
        run("pb56", PB, 8'd56, 4'd0, mk(0, 0, 0, 4'd0, 4'd2, 4'd3, NUL, 4'd1, 1, 2));
        run("rd1", RD, 8'd0, 4'd1, mk(8'd34, 1, 0, 4'd0, 4'd2, 4'd3, 4'd2, 4'd0, 1, 2));
        run("pf7", PF, 8'd7, 4'd0, mk(0, 0, 0, 4'd3, 4'd2, 4'd4, 4'd0, NUL, 1, 2));
        run("popb", OB, 8'd0, 4'd0, mk(8'd56, 1, 0, 4'd3, 4'd1, 4'd3, NUL, 4'd1, 1, 2));
        // List 7,12,34 in slots 3,0,1; later input changes must not alter the search.
        run("dv34", DV, 8'd34, 4'd0, mk(8'd34, 1, 0, 4'd3, 4'd0, 4'd2, NUL, 4'd0, 1, LAT_DV34), 1'b1);
        run("dv99", DV, 8'd99, 4'd0, mk(0, 0, 1, 4'd3, 4'd0, 4'd2, 0, 0, 0, LAT_DV99));

        for (int i = 0; i < 6; i++) begin
            run("fill", PB, 8'(100 + i), 4'd0,
                mk(0, 0, 0, 4'd3, slots[i], 4'(3 + i), NUL, (i == 0) ? 4'd0 : slots[i-1], 1, 2));
        end
        run("pbfull", PB, 8'd200, 4'd0, mk(0, 0, 1, 4'd3, 4'd7, 4'd8, 0, 0, 0, 2));
        for (int i = 0; i < 8; i++) begin
            run("popf", OF, 8'd0, 4'd0,
                mk(pdat[i], 1, 0, phead[i], (i == 7) ? NUL : 4'd7, 4'(7 - i), phead[i], NUL, 1, 2));
        end
        run("popfempty", OF, 8'd0, 4'd0, mk(0, 0, 1, NUL, NUL, 4'd0, 0, 0, 0, 2));

        run("pb1", PB, 8'd1, 4'd0, mk(0, 0, 0, 4'd0, 4'd0, 4'd1, NUL, NUL, 1, 2));
        run("pb2", PB, 8'd2, 4'd0, mk(0, 0, 0, 4'd0, 4'd1, 4'd2, NUL, 4'd0, 1, 2));
        run("pb3", PB, 8'd3, 4'd0, mk(0, 0, 0, 4'd0, 4'd2, 4'd3, NUL, 4'd1, 1, 2));
        run("ib2", IB, 8'd9, 4'd2, mk(0, 0, 0, 4'd0, 4'd2, 4'd4, 4'd2, 4'd1, 1, 2));
        run("rd3", RD, 8'd0, 4'd3, mk(8'd9, 1, 0, 4'd0, 4'd2, 4'd4, 4'd2, 4'd1, 1, 2));
        run("rd1b", RD, 8'd0, 4'd1, mk(8'd2, 1, 0, 4'd0, 4'd2, 4'd4, 4'd3, 4'd0, 1, 2));
        run("rd2", RD, 8'd0, 4'd2, mk(8'd3, 1, 0, 4'd0, 4'd2, 4'd4, NUL, 4'd3, 1, 2));
        run("ibhead", IB, 8'd8, 4'd0, mk(0, 0, 0, 4'd4, 4'd2, 4'd5, 4'd0, NUL, 1, 2));
        run("rd0", RD, 8'd0, 4'd0, mk(8'd1, 1, 0, 4'd4, 4'd2, 4'd5, 4'd1, 4'd4, 1, 2));
        run("rdinv", RD, 8'd0, 4'd5, mk(0, 0, 1, 4'd4, 4'd2, 4'd5, 0, 0, 0, 2));
        run("rdnull", RD, 8'd0, NUL, mk(0, 0, 1, 4'd4, 4'd2, 4'd5, 0, 0, 0, 2));
        run("darange", DA, 8'd0, 4'd9, mk(0, 0, 1, 4'd4, 4'd2, 4'd5, 0, 0, 0, 2));
        run("da3", DA, 8'd0, 4'd3, mk(8'd9, 1, 0, 4'd4, 4'd2, 4'd4, 4'd2, 4'd1, 1, 2));
        run("rd1c", RD, 8'd0, 4'd1, mk(8'd2, 1, 0, 4'd4, 4'd2, 4'd4, 4'd2, 4'd0, 1, 2));

        // Abort a Delete_value (match at position 3) with reset partway through.
        @(negedge clk);
        op = DV; data_in = 8'd3; op_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start = 1'b0;
        chk("abort:busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort:no_done", op_done, 0);
        end
        rst = 1'b1;
        chk_reset("released");
        run("pb42", PB, 8'd42, 4'd0, mk(0, 0, 0, 4'd0, 4'd0, 4'd1, NUL, NUL, 1, 2));
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
